// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and defaults for the two-port register-file arbiter
package regfile_arb_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with the priority pointer flop
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  owner_t ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == OWN_A) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The pointer always hands priority to the port that just lost or sat idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= OWN_A;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0] ? OWN_B : OWN_A;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - arbitrates two request ports onto one registered-read register file
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_valid,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rsp_valid,
  input  logic          a_rsp_ready,
  output logic [DW-1:0] a_rsp_data,
  input  logic          b_valid,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rsp_valid,
  input  logic          b_rsp_ready,
  output logic [DW-1:0] b_rsp_data,
  output logic [DW-1:0] rf_wrdata,
  output logic [AW-1:0] rf_address,
  output logic          rf_wren,
  output logic          rf_rden,
  input  logic [DW-1:0] rf_rddata
);

  state_t     state;
  owner_t     owner;
  logic       cmd_wr;
  logic       accept;
  logic [1:0] grant;

  assign accept  = (state == IDLE) && !RST;
  assign a_ready = accept && grant[0];
  assign b_ready = accept && grant[1];

  rr_arbiter2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     ({b_valid, a_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // rf_address/rf_wrdata double as the command register, so they hold the
  // last command outside ISSUE without a separate copy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      owner       <= OWN_A;
      cmd_wr      <= 1'b0;
      rf_address  <= '0;
      rf_wrdata   <= '0;
      rf_wren     <= 1'b0;
      rf_rden     <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[0]) begin
            owner      <= OWN_A;
            cmd_wr     <= a_wr;
            rf_address <= a_addr;
            rf_wrdata  <= a_wdata;
            rf_wren    <= a_wr;
            rf_rden    <= !a_wr;
            state      <= ISSUE;
          end else if (grant[1]) begin
            owner      <= OWN_B;
            cmd_wr     <= b_wr;
            rf_address <= b_addr;
            rf_wrdata  <= b_wdata;
            rf_wren    <= b_wr;
            rf_rden    <= !b_wr;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rf_wren <= 1'b0;
          rf_rden <= 1'b0;
          state   <= cmd_wr ? IDLE : WAIT;
        end
        WAIT: begin
          if (owner == OWN_A) begin
            a_rsp_data  <= rf_rddata;
            a_rsp_valid <= 1'b1;
          end else begin
            b_rsp_data  <= rf_rddata;
            b_rsp_valid <= 1'b1;
          end
          state <= RSP;
        end
        RSP: begin
          if ((owner == OWN_A) && a_rsp_ready) begin
            a_rsp_valid <= 1'b0;
            state       <= IDLE;
          end else if ((owner == OWN_B) && b_rsp_ready) begin
            b_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
